// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search controller.
package sar_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRIAL = 2'd1,
      DONE  = 2'd2
   } sar_state_t;
endpackage

// File: rtl/sar_search.sv
// Binary-search controller: drives a trial value to an external comparator and
// resolves one bit per TRIAL cycle, MSB first, from the returned ge answer.
module sar_search
   import sar_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_start,
   input  logic         i_ge,
   output logic [N-1:0] o_guess,
   output logic         o_busy,
   output logic         o_done,
   output logic [N-1:0] o_result
);

   localparam int IW = $clog2(N);

   sar_state_t       r_state;
   logic [IW-1:0]    r_idx;
   logic [N-1:0]     r_guess;
   logic [N-1:0]     r_result;
   logic             r_busy;
   logic             r_done;

   sar_state_t       w_state_nxt;
   logic [IW-1:0]    w_idx_nxt;
   logic [N-1:0]     w_guess_nxt;
   logic [N-1:0]     w_result_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic [N-1:0]     w_trial_guess;
   logic [N-1:0]     w_msb;

   assign w_msb = {1'b1, {(N-1){1'b0}}};

   // State and datapath registers; busy/done are registered from the next state.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_idx    <= '0;
         r_guess  <= '0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_guess  <= w_guess_nxt;
         r_result <= w_result_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_nxt = TRIAL;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         TRIAL: begin
            if (r_idx == '0) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = TRIAL;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Trial bit resolution: keep or clear the current bit, then arm the next lower one.
   always_comb begin
      w_trial_guess        = r_guess;
      w_trial_guess[r_idx] = i_ge;
      if (r_idx != '0) begin
         w_trial_guess[r_idx - IW'(1)] = 1'b1;
      end else begin
         w_trial_guess = w_trial_guess;
      end
   end

   // Datapath and output next values.
   always_comb begin
      w_idx_nxt    = r_idx;
      w_guess_nxt  = r_guess;
      w_result_nxt = r_result;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_guess_nxt = w_msb;
               w_idx_nxt   = IW'(N-1);
            end else begin
               w_guess_nxt = '0;
               w_idx_nxt   = r_idx;
            end
         end
         TRIAL: begin
            w_guess_nxt = w_trial_guess;
            if (r_idx != '0) begin
               w_idx_nxt = r_idx - IW'(1);
            end else begin
               w_result_nxt = w_trial_guess;
            end
         end
         DONE: begin
            w_guess_nxt = '0;
         end
         default: begin
            w_guess_nxt = '0;
            w_idx_nxt   = '0;
         end
      endcase
      w_busy_nxt = (w_state_nxt == TRIAL);
      w_done_nxt = (w_state_nxt == DONE);
   end

   assign o_guess  = r_guess;
   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_result = r_result;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search; the comparator loop is closed in the bench
// (ge = target >= guess) for an N=8 and an N=4 instance.
module tb_sar_search;

   logic       clk;
   logic       reset;
   logic       start8, ge8, busy8, done8;
   logic [7:0] target8, guess8, result8;
   logic       start4, ge4, busy4, done4;
   logic [3:0] target4, guess4, result4;

   int checks   = 0;
   int failures = 0;
   logic [7:0] gseq [16];

   typedef struct {
      logic [7:0] target;
      logic [7:0] exp_result;
   } vec_t;
   vec_t vecs [9];

   sar_search #(.N(8)) u_dut8 (
      .i_clk(clk), .i_reset(reset), .i_start(start8), .i_ge(ge8),
      .o_guess(guess8), .o_busy(busy8), .o_done(done8), .o_result(result8)
   );

   sar_search #(.N(4)) u_dut4 (
      .i_clk(clk), .i_reset(reset), .i_start(start4), .i_ge(ge4),
      .o_guess(guess4), .o_busy(busy4), .o_done(done4), .o_result(result4)
   );

   assign ge8 = (target8 >= guess8);
   assign ge4 = (target4 >= guess4);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // One start pulse; observes 14 cycles counting busy/done and recording guesses.
   task automatic run8(input logic [7:0] tgt, output logic [7:0] res, output int lat,
                       output int bcnt, output int dcnt);
      target8 = tgt;
      start8  = 1'b1;
      tick();
      start8 = 1'b0;
      lat  = 0;
      bcnt = 0;
      dcnt = 0;
      res  = 8'h00;
      for (int k = 1; k <= 14; k++) begin
         if (busy8) begin
            if (bcnt < 16) gseq[bcnt] = guess8;
            bcnt++;
         end
         if (done8) begin
            dcnt++;
            if (lat == 0) begin
               lat = k;
               res = result8;
            end
         end
         tick();
      end
   endtask

   initial begin
      logic [7:0] res;
      logic [7:0] r1, r2;
      int lat, bcnt, dcnt, e1, e2, nd, held_bad;
      logic [7:0] exp_seq [8];
      logic [3:0] exp_seq4 [4];

      vecs[0] = '{8'h5A, 8'h5A};
      vecs[1] = '{8'h00, 8'h00};
      vecs[2] = '{8'hFF, 8'hFF};
      vecs[3] = '{8'h80, 8'h80};
      vecs[4] = '{8'h11, 8'h11};
      vecs[5] = '{8'hEE, 8'hEE};
      vecs[6] = '{8'h01, 8'h01};
      vecs[7] = '{8'h7F, 8'h7F};
      vecs[8] = '{8'hA5, 8'hA5};
      exp_seq = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
      exp_seq4 = '{4'h8, 4'hC, 4'hA, 4'h9};

      reset = 1'b1; start8 = 1'b0; start4 = 1'b0; target8 = 8'h00; target4 = 4'h0;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("reset_guess",  {24'd0, guess8},  32'h0);
      check("reset_result", {24'd0, result8}, 32'h0);
      check("reset_busy",   {31'd0, busy8},   32'h0);
      check("reset_done",   {31'd0, done8},   32'h0);

      // Guess sequence for 0x5A
      run8(8'h5A, res, lat, bcnt, dcnt);
      for (int i = 0; i < 8; i++) check($sformatf("seq5A_%0d", i), {24'd0, gseq[i]}, {24'd0, exp_seq[i]});

      foreach (vecs[i]) begin
         run8(vecs[i].target, res, lat, bcnt, dcnt);
         check($sformatf("vec%0d_result", i), {24'd0, res}, {24'd0, vecs[i].exp_result});
         check($sformatf("vec%0d_latency", i), lat, 9);
         check($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
         check($sformatf("vec%0d_done_cycles", i), dcnt, 1);
      end

      // start held high: back-to-back searches
      target8 = 8'h11; start8 = 1'b1;
      nd = 0; e1 = 0; e2 = 0; r1 = 8'h00; r2 = 8'h00;
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (done8) begin
            if (nd == 0) begin
               e1 = e; r1 = result8; target8 = 8'hEE;
            end else if (nd == 1) begin
               e2 = e; r2 = result8;
            end
            nd++;
         end
      end
      start8 = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      check("b2b_result1", {24'd0, r1}, 32'h11);
      check("b2b_result2", {24'd0, r2}, 32'hEE);
      check("b2b_spacing", e2 - e1, 10);
      check("b2b_first_latency", e1, 9);

      // Reset during the 4th TRIAL cycle
      target8 = 8'h5A; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      check("mid_guess_before_reset", {24'd0, guess8}, 32'h50);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_guess",  {24'd0, guess8},  32'h0);
      check("rst_mid_busy",   {31'd0, busy8},   32'h0);
      check("rst_mid_done",   {31'd0, done8},   32'h0);
      check("rst_mid_result", {24'd0, result8}, 32'h0);
      tick();
      run8(8'h5A, res, lat, bcnt, dcnt);
      check("after_rst_result", {24'd0, res}, 32'h5A);
      check("after_rst_latency", lat, 9);

      // Extra start pulses in TRIAL and DONE are ignored
      run8(8'h33, res, lat, bcnt, dcnt);
      check("prior_result", {24'd0, result8}, 32'h33);
      target8 = 8'h44; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      dcnt = 0; held_bad = 0; lat = 0; res = 8'h00;
      for (int k = 1; k <= 24; k++) begin
         start8 = (k == 3) || (done8 && dcnt == 0);
         if (busy8 && result8 !== 8'h33) held_bad++;
         if (done8) begin
            dcnt++;
            if (lat == 0) begin
               lat = k; res = result8;
            end
         end
         tick();
      end
      start8 = 1'b0;
      check("extra_start_done_count", dcnt, 1);
      check("extra_start_result_held", held_bad, 0);
      check("extra_start_result", {24'd0, res}, 32'h44);
      check("extra_start_latency", lat, 9);

      // N=4, target 0x9
      target4 = 4'h9; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      bcnt = 0; dcnt = 0; lat = 0;
      for (int k = 1; k <= 10; k++) begin
         if (busy4) begin
            if (bcnt < 4) check($sformatf("n4_seq_%0d", bcnt), {28'd0, guess4}, {28'd0, exp_seq4[bcnt]});
            bcnt++;
         end
         if (done4) begin
            dcnt++;
            if (lat == 0) begin
               lat = k;
               check("n4_result", {28'd0, result4}, 32'h9);
            end
         end
         tick();
      end
      check("n4_latency", lat, 5);
      check("n4_busy_cycles", bcnt, 4);
      check("n4_done_cycles", dcnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller that finds an unknown N-bit value by binary search against an external magnitude comparator. It drives a trial value onto `guess` and reads back a single greater-or-equal result from the comparator: the comparator answers "how do a and b relate", and this block uses those answers to produce the value. It sits beside the team's N-bit comparator. Typical uses are ADC-style SAR loops and threshold calibration.

## Interface
Parameters:
- N, default 8, width of the searched value (N ≥ 2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new search; accepted only in IDLE
- ge  input  1  comparator result, 1 when target ≥ `guess`; combinational from `guess`, sampled every TRIAL cycle
- guess  output  N  registered trial value driven to the comparator's b input
- busy  output  1  high while a search is in progress (TRIAL state)
- done  output  1  one-cycle pulse when `result` becomes valid
- result  output  N  final searched value; holds until the next search completes or reset

One clock domain. Reset is synchronous and active-high.

## Operation
- States: IDLE, TRIAL, DONE. Internal registers: state, bit index `idx` (width ⌈log2 N⌉), `guess`, `result`.
- IDLE:
  - `guess` = 0, busy = 0, done = 0.
  - On `start` = 1: set `guess` = 1<<(N-1), `idx` = N-1, go to TRIAL.
- TRIAL:
  - busy = 1.
  - Each cycle, sample `ge`. If `ge` = 0, clear bit `idx` of `guess`; if `ge` = 1, keep it.
  - If `idx` > 0: also set bit `idx`-1 of `guess`, decrement `idx`, stay in TRIAL.
  - If `idx` = 0: load `result` with the updated `guess` and go to DONE.
- DONE:
  - done = 1 for exactly one cycle, busy = 0.
  - `guess` holds the final value for this cycle.
  - Next state is IDLE unconditionally.
- `start` is ignored in TRIAL and DONE; it is not queued. `start` held high re-launches a search from the first IDLE cycle after DONE.
- `result` keeps its old value throughout a new search and changes only on the TRIAL→DONE edge.
- Arithmetic: bit set and clear only, no adders. The search is unsigned. Target 2^N−1 yields all ones; target 0 yields 0.
- The output is always the largest v with target ≥ v, i.e. it equals the target for any in-range target.

## Timing
- Reset values: state = IDLE, `guess` = 0, `result` = 0, busy = 0, done = 0, `idx` = 0.
- Reset dominates every other input, including mid-search. The next cycle after reset is IDLE with all outputs at their reset values.
- For `start` sampled at edge E:
  - TRIAL occupies cycles E+1 … E+N, with the first `guess` = 1<<(N-1) visible after edge E.
  - done is high in cycle E+N+1 and `result` is valid from the same edge.
- Total latency is N+1 cycles from `start` to done. Back-to-back searches with `start` held high take N+2 cycles each.
- `ge` must settle combinationally within the same cycle from the registered `guess`. No pipeline stage is allowed between them.

## Structure
- Package `sar_pkg` holds the typedef enum logic [1:0] `sar_state_t` {IDLE, TRIAL, DONE}. No other shared constants.
- Single module with no sub-modules. The testbench closes the loop with the existing N-bit comparator, using target on a, `guess` on b, and the comparator's gte output driving `ge`.

## Test plan
- N=8, target 0x5A, pulse `start`:
  - `guess` sequence is 0x80, 0x40, 0x60, 0x50, 0x58, 0x5C, 0x5A, 0x5B.
  - done pulses exactly 9 cycles after `start`, with `result` = 0x5A.
- N=8, targets 0x00, 0xFF and 0x80 in turn: `result` equals the target each time, busy is high for exactly 8 cycles, and done is high for exactly 1 cycle.
- `start` held high continuously, target alternating 0x11 then 0xEE between searches: results are 0x11 then 0xEE, and done pulses are 10 cycles apart.
- Reset asserted in the 4th TRIAL cycle of a search for 0x5A: the next cycle shows IDLE with `guess` = 0, busy = 0, done = 0 and `result` = 0. A new `start` then completes normally.
- Extra `start` pulses during TRIAL and during the DONE cycle are ignored, and exactly one done is produced. `result` keeps its prior value (e.g. 0x33) until the new done.
- N=4, target 0x9: the `guess` sequence is 0x8, 0xC, 0xA, 0x9, and done arrives 5 cycles after `start` with `result` = 0x9.
